// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: sequencer state,
// default key constant and the byte-enable merge helper.
// Imported by regfile_clear_seq and regfile_mp.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [15:0] KEY_DEFAULT = 16'h0032;

    // The helper works on the widest supported word; callers zero-extend
    // their operands and keep the low DATA_W bits of the result.
    localparam int MERGE_MAX_W  = 128;
    localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

    // Replace the bytes of old_w selected by be with the bytes of new_w.
    function automatic logic [MERGE_MAX_W-1:0] merge_be(
        input logic [MERGE_MAX_W-1:0]  old_w,
        input logic [MERGE_MAX_W-1:0]  new_w,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] r;
        r = old_w;
        for (int b = 0; b < MERGE_MAX_BE; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: CLEAR/RUN FSM plus the clear index counter.
// Ports: clk/rst, clr_req (re-run clear from RUN), clr_we/clr_addr (zero
// write strobe and address), ready (RUN), busy_cnt (current clear index).
// All outputs come straight from state registers; latency 1 cycle.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready,
    output logic [ADDR_W-1:0] busy_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_CLEAR: begin
                // Counter wraps to 0 on the cycle that clears the last entry.
                cnt_nxt = cnt + 1'b1;
                if (cnt == {ADDR_W{1'b1}}) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        clr_we   = (state == ST_CLEAR);
        ready    = (state == ST_RUN);
        clr_addr = cnt;
        busy_cnt = cnt;
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, one byte-enabled
// write port with write-first bypass, hardware clear after reset/clr_req.
// Ports: clk/rst, clr_req, rd_en/rd_addr -> rd_data/rd_valid (1 cycle),
// wr_en/wr_addr/wr_data/wr_be, ready, busy_cnt, key_access (constant KEY).
// No backpressure; requests while ready=0 are dropped.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 10,
    parameter int          NUM_RD = 2,
    parameter logic [15:0] KEY    = KEY_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_req,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    output logic                     ready,
    output logic [ADDR_W-1:0]        busy_cnt,
    output logic [15:0]              key_access
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]      mem [DEPTH];
    logic                   clr_we;
    logic [ADDR_W-1:0]      clr_addr;
    logic [MERGE_MAX_W-1:0] merged_full;
    logic [DATA_W-1:0]      wr_merged;

    assign key_access = KEY;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready),
        .busy_cnt (busy_cnt)
    );

    // The merged word feeds both the array write and the same-cycle bypass,
    // so a colliding read sees exactly what the array will hold afterwards.
    assign merged_full = merge_be(MERGE_MAX_W'(mem[wr_addr]),
                                  MERGE_MAX_W'(wr_data),
                                  MERGE_MAX_BE'(wr_be));
    assign wr_merged   = merged_full[DATA_W-1:0];

    // Array storage carries no reset; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (ready && wr_en) begin
            mem[wr_addr] <= wr_merged;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic [DATA_W-1:0] q;
        logic              v;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign hit  = wr_en && (wr_addr == addr);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
                v <= 1'b0;
            end else begin
                v <= ready && rd_en[i];
                if (ready && rd_en[i]) begin
                    q <= hit ? wr_merged : mem[addr];
                end
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = q;
        assign rd_valid[i]                 = v;
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NR    = 2;
    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_req;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_valid;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [DW/8-1:0]   wr_be;
    logic              ready;
    logic [AW-1:0]     busy_cnt;
    logic [15:0]       key_access;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: plain array of words plus last returned word per port.
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_rd [NR];

    regfile_mp #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .KEY    (16'h0032)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .ready      (ready),
        .busy_cnt   (busy_cnt),
        .key_access (key_access)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [DW/8-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < DW/8; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
    endtask

    task automatic idle();
        rd_en   = '0;
        wr_en   = 1'b0;
        clr_req = 1'b0;
        wr_be   = '0;
    endtask

    // One RUN-mode cycle: write lands in the model first, so a colliding
    // read gets the merged word (write-first).
    task automatic op(input string tag, input logic [NR-1:0] re,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [DW/8-1:0] be,
                      input logic clr);
        rd_en   = re;
        rd_addr = {a1, a0};
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        clr_req = clr;
        if (we) model[wa] = byte_merge(model[wa], wd, be);
        if (re[0]) exp_rd[0] = model[a0];
        if (re[1]) exp_rd[1] = model[a1];
        step();
        chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(re));
        chk({tag, ".rd_data0"}, 64'(rd_data[DW-1:0]), 64'(exp_rd[0]));
        chk({tag, ".rd_data1"}, 64'(rd_data[2*DW-1:DW]), 64'(exp_rd[1]));
        chk({tag, ".ready"}, 64'(ready), 64'(!clr));
        idle();
    endtask

    // Counts edges until ready rises while hammering the ports, which must
    // all be ignored.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        rd_en   = 2'b11;
        rd_addr = {10'd9, 10'd0};
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 32'hFFFF_FFFF;
        wr_be   = 4'hF;
        clr_req = 1'b1;
        while (!ready && n < 3000) begin
            step();
            n++;
            chk({tag, ".rd_valid_in_clear"}, 64'(rd_valid), 64'(0));
        end
        chk({tag, ".clear_cycles"}, 64'(n), 64'(DEPTH));
        chk({tag, ".busy_after"}, 64'(busy_cnt), 64'(0));
        chk({tag, ".key"}, 64'(key_access), 64'(16'h0032));
        idle();
        model_clear();
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        idle();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        model_clear();

        // Reset state
        step();
        step();
        chk("rst.ready", 64'(ready), 64'(0));
        chk("rst.busy", 64'(busy_cnt), 64'(0));
        chk("rst.rd_valid", 64'(rd_valid), 64'(0));
        chk("rst.rd_data", 64'(rd_data), 64'(0));
        chk("rst.key", 64'(key_access), 64'(16'h0032));

        // Initial clear
        rst = 1'b0;
        wait_clear("init");
        op("rd0_511", 2'b11, 10'd0, 10'd511, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
        op("rd1023", 2'b01, 10'd1023, 10'd0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);

        // Byte enables
        op("be_full", 2'b00, 10'd0, 10'd0, 1'b1, 10'd5, 32'hAABBCCDD, 4'hF, 1'b0);
        op("be_part", 2'b00, 10'd0, 10'd0, 1'b1, 10'd5, 32'h11223344, 4'b0101, 1'b0);
        op("be_zero", 2'b00, 10'd0, 10'd0, 1'b1, 10'd5, 32'h55555555, 4'h0, 1'b0);
        op("be_read", 2'b01, 10'd5, 10'd0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
        chk("be_value", 64'(rd_data[DW-1:0]), 64'(32'hAA22CC44));

        // Bypass on both ports
        op("bypass", 2'b11, 10'd7, 10'd7, 1'b1, 10'd7, 32'hDEADBEEF, 4'hF, 1'b0);
        chk("bypass_p0", 64'(rd_data[DW-1:0]), 64'(32'hDEADBEEF));
        chk("bypass_p1", 64'(rd_data[2*DW-1:DW]), 64'(32'hDEADBEEF));

        // Independent ports: port 1 keeps DEADBEEF
        op("wr3", 2'b00, 10'd0, 10'd0, 1'b1, 10'd3, 32'h3, 4'hF, 1'b0);
        op("indep", 2'b01, 10'd3, 10'd0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
        chk("indep_p1", 64'(rd_data[2*DW-1:DW]), 64'(32'hDEADBEEF));

        // Randomized traffic over a narrow address window to force collisions
        for (int k = 0; k < 300; k++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, 15));
            op("rand", NR'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15)),
               AW'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)), 1'b0);
        end

        // clr_req mid-run, with a same-cycle write and read
        op("wr9", 2'b00, 10'd0, 10'd0, 1'b1, 10'd9, 32'h99, 4'hF, 1'b0);
        op("clr", 2'b01, 10'd9, 10'd0, 1'b1, 10'd10, 32'h1010, 4'hF, 1'b1);
        chk("clr_served", 64'(rd_data[DW-1:0]), 64'(32'h99));
        chk("clr_busy0", 64'(busy_cnt), 64'(0));
        wait_clear("clrreq");
        op("after_clr", 2'b11, 10'd9, 10'd10, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);
        op("init_ignored", 2'b01, 10'd0, 10'd0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b0);

        // Reset in the middle of a clear
        op("clr2", 2'b00, 10'd0, 10'd0, 1'b0, 10'd0, 32'd0, 4'h0, 1'b1);
        n = 0;
        while (busy_cnt != 10'd300 && n < 2000) begin
            step();
            n++;
        end
        chk("reach300", 64'(busy_cnt), 64'(300));
        rst = 1'b1;
        #1;
        chk("midrst.busy", 64'(busy_cnt), 64'(0));
        chk("midrst.ready", 64'(ready), 64'(0));
        chk("midrst.rd_data", 64'(rd_data), 64'(0));
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        step();
        rst = 1'b0;
        wait_clear("midrst");
        op("final", 2'b11, 10'd1023, 10'd300, 1'b1, 10'd300, 32'h12345678, 4'b1100, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
